// File: rtl/nios_trigger_out_pio_if.sv
// Avalon-MM register-bus bundle for nios_trigger_out_pio.
// The master modport is the Nios II side and the slave modport is the PIO.
interface nios_trigger_out_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_trigger_out_pio.sv
// Software-driven 1-bit trigger output: a timed pulse or a level held until the fabric acknowledges.
// Optional macro ACK_SYNC_EN inserts a 2-flop synchronizer on ack_in.
module nios_trigger_out_pio #(
  parameter int PULSE_W     = 16,
  parameter int DEFAULT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios_trigger_out_pio_if.slave  bus,
  input  logic                   ack_in,
  output logic                   out_port
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 out_q, out_d;
  logic                 mode_q, mode_d;
  logic [PULSE_W-1:0]   len_q, len_d;
  logic [PULSE_W-1:0]   cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 ack_eff_s;
  logic                 wr_s, wr_data_s, wr_ctrl_s, wr_len_s, wr_stat_s;
  logic                 done_set_s, ovr_set_s, busy_s;

`ifdef ACK_SYNC_EN
  logic [1:0] ack_sync_q, ack_sync_d;

  always_comb begin
    ack_sync_d = {ack_sync_q[0], ack_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync_q <= 2'b00;
    end else begin
      ack_sync_q <= ack_sync_d;
    end
  end

  assign ack_eff_s = ack_sync_q[1];
`else
  assign ack_eff_s = ack_in;
`endif

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign wr_data_s = wr_s && (bus.address == 2'd0);
  assign wr_ctrl_s = wr_s && (bus.address == 2'd1);
  assign wr_len_s  = wr_s && (bus.address == 2'd2);
  assign wr_stat_s = wr_s && (bus.address == 2'd3);
  assign busy_s    = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    len_d      = len_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    done_set_s = 1'b0;
    ovr_set_s  = 1'b0;

    if (wr_ctrl_s) begin
      mode_d = bus.writedata[0];
    end else begin
      mode_d = mode_q;
    end

    if (wr_len_s) begin
      len_d = bus.writedata[PULSE_W-1:0];
    end else begin
      len_d = len_q;
    end

    // Abort beats everything else; an idle abort is harmless.
    if (wr_data_s && !bus.writedata[0]) begin
      out_d   = 1'b0;
      cnt_d   = {PULSE_W{1'b0}};
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_data_s && bus.writedata[0]) begin
            if (mode_q) begin
              out_d   = 1'b1;
              state_d = ST_WAIT_ACK;
            end else if (len_q != {PULSE_W{1'b0}}) begin
              out_d   = 1'b1;
              cnt_d   = len_q;
              state_d = ST_PULSE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PULSE: begin
          ovr_set_s = wr_data_s && bus.writedata[0];
          cnt_d     = cnt_q - PULSE_W'(1);
          if (cnt_q == PULSE_W'(1)) begin
            out_d      = 1'b0;
            done_set_s = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_PULSE;
          end
        end
        ST_WAIT_ACK: begin
          ovr_set_s = wr_data_s && bus.writedata[0];
          if (ack_eff_s) begin
            out_d      = 1'b0;
            done_set_s = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
        default: begin
          out_d   = 1'b0;
          cnt_d   = {PULSE_W{1'b0}};
          state_d = ST_IDLE;
        end
      endcase
    end

    // W1C first so a same-cycle hardware set wins.
    if (wr_stat_s && bus.writedata[1]) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
    if (wr_stat_s && bus.writedata[2]) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (done_set_s) begin
      done_d = 1'b1;
    end else begin
      done_d = done_d;
    end
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end
  end

  always_comb begin
    case (bus.address)
      2'd0:    rdata_d = {31'd0, out_q};
      2'd1:    rdata_d = {31'd0, mode_q};
      2'd2:    rdata_d = 32'(len_q);
      2'd3:    rdata_d = {29'd0, ovr_q, done_q, busy_s};
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      mode_q  <= 1'b0;
      len_q   <= PULSE_W'(DEFAULT_LEN);
      cnt_q   <= {PULSE_W{1'b0}};
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  assign out_port     = out_q;
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_nios_trigger_out_pio.sv
// Directed bench for nios_trigger_out_pio; inputs change and outputs are sampled on the falling edge.
module tb_nios_trigger_out_pio;
  logic clk;
  logic reset_n;
  logic ack_in;
  logic out_port;
  int   n_checks;
  int   n_fail;

  nios_trigger_out_pio_if bus ();

  nios_trigger_out_pio dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .ack_in   (ack_in),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACK_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; the write lands on the rising edge in between.
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  initial begin
    logic [31:0] rd;
    int          n;

    n_checks       = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    ack_in         = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_out", {31'd0, out_port}, 32'd0);
    check("rst_rdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    rd_reg(2'd2, rd); check("rst_len", rd, 32'd4);
    rd_reg(2'd3, rd); check("rst_status", rd, 32'd0);
    rd_reg(2'd1, rd); check("rst_ctrl", rd, 32'd0);

    // Pulse of 4 cycles
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd2, 32'd4);
    wr_reg(2'd0, 32'd1);
    check("pulse_c1", {31'd0, out_port}, 32'd1);
    rd_reg(2'd3, rd); check("pulse_busy", rd, 32'd1);
    check("pulse_c2", {31'd0, out_port}, 32'd1);
    @(negedge clk); check("pulse_c3", {31'd0, out_port}, 32'd1);
    @(negedge clk); check("pulse_c4", {31'd0, out_port}, 32'd1);
    @(negedge clk); check("pulse_end", {31'd0, out_port}, 32'd0);
    rd_reg(2'd3, rd); check("pulse_done", rd, 32'd2);
    rd_reg(2'd0, rd); check("pulse_data", rd, 32'd0);

    // Handshake, ack 10 cycles after trigger
    wr_reg(2'd3, 32'd2);
    wr_reg(2'd1, 32'd1);
    wr_reg(2'd0, 32'd1);
    check("hs_start", {31'd0, out_port}, 32'd1);
    repeat (9) @(negedge clk);
    check("hs_hold", {31'd0, out_port}, 32'd1);
    ack_in = 1'b1;
    for (int i = 0; i < ACK_LAT - 1; i++) begin
      @(negedge clk);
      check("hs_sync_hold", {31'd0, out_port}, 32'd1);
    end
    @(negedge clk);
    check("hs_release", {31'd0, out_port}, 32'd0);
    ack_in = 1'b0;
    rd_reg(2'd3, rd); check("hs_done", rd, 32'd2);
    wr_reg(2'd3, 32'd2);
    rd_reg(2'd3, rd); check("hs_w1c", rd, 32'd0);
    repeat (3) @(negedge clk);

`ifndef ACK_SYNC_EN
    // Ack present only during the trigger-write cycle must not release the line
    ack_in = 1'b1;
    wr_reg(2'd0, 32'd1);
    ack_in = 1'b0;
    repeat (3) @(negedge clk);
    check("hs_early_ack", {31'd0, out_port}, 32'd1);
    wr_reg(2'd0, 32'd0);
    rd_reg(2'd3, rd); check("hs_abort", rd, 32'd0);
`endif

    // Overrun then abort of a long pulse
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd2, 32'd100);
    wr_reg(2'd0, 32'd1);
    repeat (4) @(negedge clk);
    wr_reg(2'd0, 32'd1);
    rd_reg(2'd3, rd); check("ovr_set", rd, 32'd5);
    repeat (2) @(negedge clk);
    wr_reg(2'd0, 32'd0);
    check("abort_out", {31'd0, out_port}, 32'd0);
    rd_reg(2'd3, rd); check("abort_status", rd, 32'd4);
    wr_reg(2'd3, 32'd4);
    rd_reg(2'd3, rd); check("ovr_w1c", rd, 32'd0);

    // Zero length is ignored
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd0, 32'd1);
    check("len0_out", {31'd0, out_port}, 32'd0);
    rd_reg(2'd3, rd); check("len0_status", rd, 32'd0);

    // Maximum length
    wr_reg(2'd2, 32'h0000_FFFF);
    wr_reg(2'd0, 32'd1);
    n = 0;
    while (out_port === 1'b1 && n < 70000) begin
      n++;
      @(negedge clk);
    end
    check("len_max", n, 32'd65535);

    // Done set coinciding with W1C of done
    wr_reg(2'd3, 32'd2);
    wr_reg(2'd2, 32'd2);
    wr_reg(2'd0, 32'd1);
    @(negedge clk);
    wr_reg(2'd3, 32'd2);
    check("coinc_out", {31'd0, out_port}, 32'd0);
    rd_reg(2'd3, rd); check("coinc_done", rd, 32'd2);

    // Readback
    wr_reg(2'd1, 32'd1);
    wr_reg(2'd2, 32'h0000_1234);
    rd_reg(2'd1, rd); check("rb_ctrl", rd, 32'd1);
    rd_reg(2'd2, rd); check("rb_len", rd, 32'h0000_1234);

    // Reset in the middle of a pulse
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd0, 32'd1);
    bus.address = 2'd2;
    @(negedge clk);
    check("mid_pulse", {31'd0, out_port}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_out", {31'd0, out_port}, 32'd0);
    check("rst_mid_rdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_reg(2'd2, rd); check("rst_mid_len", rd, 32'd4);
    rd_reg(2'd3, rd); check("rst_mid_status", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
